// File: rtl/mem_stage_lsu.sv
// Memory-access stage: req/ack data-memory handshake with byte enables and load formatting.
// Optional feature: define MEMLSU_MISALIGN_TRAP_EN to trap misaligned accesses (misalign_err).
module mem_stage_lsu #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ex_mem_valid,
  input  logic [6:0]           ex_mem_inst_opcode,
  input  logic [2:0]           ex_mem_funct3,
  input  logic [REG_WIDTH-1:0] ex_mem_alu_out,
  input  logic [REG_WIDTH-1:0] ex_mem_dataB,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic [REG_WIDTH-1:0] DMEM_data_out,
  output logic                 mem_stall
`ifdef MEMLSU_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_err
`endif
);

  // Byte-lane logic below is hard-wired for a 32-bit datapath.
  if (REG_WIDTH != 32 || REG_ADDR_WIDTH < 1) begin : g_cfg_check
    $error("mem_stage_lsu supports REG_WIDTH == 32 only");
  end

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;

  logic        is_load, is_store, legal_load, legal_store;
  logic        access, misaligned, start;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;

  always_comb begin
    is_load     = (ex_mem_inst_opcode == OpLoad);
    is_store    = (ex_mem_inst_opcode == OpStore);
    legal_load  = ex_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    legal_store = ex_mem_funct3 inside {3'b000, 3'b001, 3'b010};
    access      = ex_mem_valid && ((is_load && legal_load) || (is_store && legal_store));
    misaligned  = ((ex_mem_funct3[1:0] == 2'b01) && ex_mem_alu_out[0]) ||
                  ((ex_mem_funct3[1:0] == 2'b10) && (ex_mem_alu_out[1:0] != 2'b00));
`ifdef MEMLSU_MISALIGN_TRAP_EN
    start = access && !misaligned;
`else
    start = access;
`endif
    // Force-align the lane offset to the access size.
    case (ex_mem_funct3[1:0])
      2'b01:   off = {ex_mem_alu_out[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = ex_mem_alu_out[1:0];
    endcase

    be_d    = 4'b1111;
    wdata_d = '0;
    if (is_store) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{ex_mem_dataB[7:0]}};
        end
        2'b01: begin
          be_d    = off[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{ex_mem_dataB[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = ex_mem_dataB;
        end
      endcase
    end
  end

  always_comb begin
    byte_lane = dmem_rdata[8*ld_off_q +: 8];
    half_lane = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_funct3_q)
      3'b000:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_fmt = {24'b0, byte_lane};
      3'b101:  load_fmt = {16'b0, half_lane};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    case (state_q)
      StIdle:  mem_stall = start;
      StWait:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= 4'b0;
      DMEM_data_out <= '0;
      ld_funct3_q   <= 3'b0;
      ld_off_q      <= 2'b0;
`ifdef MEMLSU_MISALIGN_TRAP_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
`ifdef MEMLSU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (start) begin
            dmem_req    <= 1'b1;
            dmem_we     <= is_store;
            dmem_addr   <= {ex_mem_alu_out[31:2], 2'b00};
            dmem_be     <= be_d;
            dmem_wdata  <= wdata_d;
            ld_funct3_q <= ex_mem_funct3;
            ld_off_q    <= off;
            state_q     <= StWait;
          end
`ifdef MEMLSU_MISALIGN_TRAP_EN
          else if (access && misaligned) begin
            misalign_err  <= 1'b1;
            DMEM_data_out <= '0;
          end
`endif
        end
        StWait: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dmem_we) DMEM_data_out <= load_fmt;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_stage_lsu;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAlu   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_mem_valid;
  logic [6:0]  ex_mem_inst_opcode;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_out, ex_mem_dataB;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, DMEM_data_out;
  logic [3:0]  dmem_be;
`ifdef MEMLSU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ex_mem_valid       (ex_mem_valid),
    .ex_mem_inst_opcode (ex_mem_inst_opcode),
    .ex_mem_funct3      (ex_mem_funct3),
    .ex_mem_alu_out     (ex_mem_alu_out),
    .ex_mem_dataB       (ex_mem_dataB),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .DMEM_data_out      (DMEM_data_out),
    .mem_stall          (mem_stall)
`ifdef MEMLSU_MISALIGN_TRAP_EN
    ,
    .misalign_err       (misalign_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One access: IDLE cycle, nwait+1 WAIT cycles (ack in the last), then DONE.
  task automatic do_access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] dat, input int nwait,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input int exp_stall, input logic [31:0] exp_out);
    int stalls = 0;
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; ex_mem_inst_opcode = op; ex_mem_funct3 = f3;
    ex_mem_alu_out = addr; ex_mem_dataB = dat; dmem_ack = 1'b0;
    @(negedge clk);
    stalls += int'(mem_stall);
    check({tag, ".idle_req"}, 32'(dmem_req), 32'd0);
    for (int w = 0; w <= nwait; w++) begin
      @(posedge clk); #1;
      dmem_ack   = (w == nwait);
      dmem_rdata = (w == nwait) ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      stalls += int'(mem_stall);
      check({tag, ".req"}, 32'(dmem_req), 32'd1);
      check({tag, ".addr"}, dmem_addr, exp_addr);
      check({tag, ".be"}, 32'(dmem_be), 32'(exp_be));
      check({tag, ".we"}, 32'(dmem_we), (op == OpStore) ? 32'd1 : 32'd0);
      if (op == OpStore) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    stalls += int'(mem_stall);
    check({tag, ".done_req"}, 32'(dmem_req), 32'd0);
    check({tag, ".data_out"}, DMEM_data_out, exp_out);
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ex_mem_valid = 1'b0; ex_mem_inst_opcode = 7'b0; ex_mem_funct3 = 3'b0;
    ex_mem_alu_out = '0; ex_mem_dataB = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.we", 32'(dmem_we), 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check("rst.wdata", dmem_wdata, 32'd0);
    check("rst.be", 32'(dmem_be), 32'd0);
    check("rst.data_out", DMEM_data_out, 32'd0);
    check("rst.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset during WAIT of a store; a late ack must be ignored.
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; ex_mem_inst_opcode = OpStore; ex_mem_funct3 = 3'b010;
    ex_mem_alu_out = 32'h100; ex_mem_dataB = 32'h5555_5555;
    @(negedge clk);
    check("rstwait.idle_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstwait.req", 32'(dmem_req), 32'd1);
    reset_n = 1'b0; ex_mem_valid = 1'b0;
    #1;
    check("rstwait.req_cleared", 32'(dmem_req), 32'd0);
    check("rstwait.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle();
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("rstwait.ack_req", 32'(dmem_req), 32'd0);
    idle_cycle();
    @(negedge clk);
    check("rstwait.post_req", 32'(dmem_req), 32'd0);
    check("rstwait.post_we", 32'(dmem_we), 32'd0);
    check("rstwait.post_stall", 32'(mem_stall), 32'd0);

    do_access("lw", OpLoad, 3'b010, 32'h40, 32'h0, 0, 32'hDEAD_BEEF, 32'h40, 4'b1111, 32'h0,
              2, 32'hDEAD_BEEF);
    do_access("lb", OpLoad, 3'b000, 32'h43, 32'h0, 0, 32'h80FF_1234, 32'h40, 4'b1111, 32'h0,
              2, 32'hFFFF_FF80);
    do_access("lbu", OpLoad, 3'b100, 32'h43, 32'h0, 0, 32'h80FF_1234, 32'h40, 4'b1111, 32'h0,
              2, 32'h0000_0080);
    do_access("lhu", OpLoad, 3'b101, 32'h42, 32'h0, 1, 32'h80FF_1234, 32'h40, 4'b1111, 32'h0,
              3, 32'h0000_80FF);
    do_access("lh", OpLoad, 3'b001, 32'h42, 32'h0, 0, 32'h80FF_1234, 32'h40, 4'b1111, 32'h0,
              2, 32'hFFFF_80FF);
    do_access("lb0", OpLoad, 3'b000, 32'h40, 32'h0, 0, 32'h80FF_1234, 32'h40, 4'b1111, 32'h0,
              2, 32'h0000_0034);
    do_access("sb", OpStore, 3'b000, 32'h21, 32'hA5, 3, 32'h0, 32'h20, 4'b0010, 32'hA5A5_A5A5,
              5, 32'h0000_0034);
    do_access("sh", OpStore, 3'b001, 32'h32, 32'h1234, 0, 32'h0, 32'h30, 4'b1100,
              32'h1234_1234, 2, 32'h0000_0034);
    do_access("sw_b2b", OpStore, 3'b010, 32'h34, 32'hCAFE_F00D, 0, 32'h0, 32'h34, 4'b1111,
              32'hCAFE_F00D, 2, 32'h0000_0034);

    // Illegal funct3 and non-memory opcode: no request, no stall, output held.
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; ex_mem_inst_opcode = OpLoad; ex_mem_funct3 = 3'b011;
    ex_mem_alu_out = 32'h40;
    @(negedge clk);
    check("ill_ld.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    ex_mem_inst_opcode = OpStore; ex_mem_funct3 = 3'b100;
    @(negedge clk);
    check("ill_ld.req", 32'(dmem_req), 32'd0);
    check("ill_st.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    ex_mem_inst_opcode = OpAlu; ex_mem_funct3 = 3'b000;
    @(negedge clk);
    check("ill_st.req", 32'(dmem_req), 32'd0);
    check("alu.stall", 32'(mem_stall), 32'd0);
    idle_cycle();
    dmem_ack = 1'b1;
    @(negedge clk);
    check("alu.req", 32'(dmem_req), 32'd0);
    check("alu.data_out", DMEM_data_out, 32'h0000_0034);
    idle_cycle();
    @(negedge clk);
    check("idle_ack.req", 32'(dmem_req), 32'd0);
    check("idle_ack.stall", 32'(mem_stall), 32'd0);

`ifdef MEMLSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; ex_mem_inst_opcode = OpLoad; ex_mem_funct3 = 3'b010;
    ex_mem_alu_out = 32'h45;
    @(negedge clk);
    check("mis.stall", 32'(mem_stall), 32'd0);
    check("mis.err_before", 32'(misalign_err), 32'd0);
    idle_cycle();
    @(negedge clk);
    check("mis.err", 32'(misalign_err), 32'd1);
    check("mis.req", 32'(dmem_req), 32'd0);
    check("mis.data_out", DMEM_data_out, 32'd0);
    idle_cycle();
    @(negedge clk);
    check("mis.err_pulse", 32'(misalign_err), 32'd0);
    check("mis.req2", 32'(dmem_req), 32'd0);
`else
    do_access("mis_lw", OpLoad, 3'b010, 32'h45, 32'h0, 0, 32'h1122_3344, 32'h44, 4'b1111,
              32'h0, 2, 32'h1122_3344);
    do_access("mis_lh", OpLoad, 3'b001, 32'h43, 32'h0, 0, 32'h80FF_1234, 32'h40, 4'b1111,
              32'h0, 2, 32'hFFFF_80FF);
    do_access("mis_sh", OpStore, 3'b001, 32'h51, 32'hBEEF, 0, 32'h0, 32'h50, 4'b0011,
              32'hBEEF_BEEF, 2, 32'hFFFF_80FF);
`endif
    idle_cycle();
    @(negedge clk);
    check("end.req", 32'(dmem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU result (address) and data B (store data) from EX/MEM.
- Runs a req/ack transaction with the data memory, with byte-enable generation and load extraction/extension.
- Drives DMEM_data_out to MEM/WB and stalls the pipeline while a transaction is outstanding.

Parameters:
- REG_WIDTH, 32, datapath/address width; fixed at 32 for byte-lane logic.
- REG_ADDR_WIDTH, 5, register index width; carried for consistency, unused internally.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ex_mem_valid  in  1  EX/MEM slot holds a live instruction.
- ex_mem_inst_opcode  in  7  opcode; 0000011 = load, 0100011 = store.
- ex_mem_funct3  in  3  access size/sign.
- ex_mem_alu_out  in  REG_WIDTH  byte address.
- ex_mem_dataB  in  REG_WIDTH  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  REG_WIDTH  word address, bits [1:0] = 0.
- dmem_wdata  out  REG_WIDTH  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  transaction complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  REG_WIDTH  read word.
- DMEM_data_out  out  REG_WIDTH  formatted load result to MEM/WB.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB must not capture.
- misalign_err  out  1  present only with MEMLSU_MISALIGN_TRAP_EN.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, DMEM_data_out, misalign_err = 0.
  - Reset mid-transaction abandons it; any later dmem_ack is ignored.
- Access condition: ex_mem_valid=1, opcode is load or store, and funct3 is legal.
  - Load legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store legal funct3: 000 SB, 001 SH, 010 SW.
  - Any other combination is no access: no request, no stall, DMEM_data_out held.
- IDLE:
  - mem_stall = access (combinational).
  - On access, register dmem_req=1, dmem_we (1 for store), dmem_addr = {addr[31:2], 2'b00}, dmem_be, dmem_wdata; go to WAIT.
- WAIT:
  - mem_stall = 1.
  - All dmem_* outputs held stable until dmem_ack.
  - On dmem_ack: dmem_req deasserts at the next edge; for a load, the formatted dmem_rdata is registered into DMEM_data_out; go to DONE.
- DONE:
  - mem_stall = 0 for exactly one cycle so MEM/WB captures DMEM_data_out. No new access starts in this cycle.
  - Go to IDLE.
- Latency: 3 cycles minimum per access (ack in the first WAIT cycle); each extra wait cycle adds 1. Non-memory instructions pass in 1 cycle.
- Store byte enables and data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{dataB[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{dataB[15:0]}}.
  - SW: be = 4'b1111; wdata = dataB.
- Loads:
  - dmem_be = 4'b1111.
  - Selected lane: byte at addr[1:0], half at addr[1].
  - Lane is sign-extended (LB/LH) or zero-extended (LBU/LHU). LW passes the word through.
- Store completion leaves DMEM_data_out unchanged.
- dmem_ack in IDLE or DONE is ignored.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Handling is set by the optional feature below.

Optional Feature:
- MEMLSU_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no request and causes no stall.
  - misalign_err pulses 1 for one cycle (registered, asserted the cycle after detection).
  - DMEM_data_out is cleared to 0.
- MEMLSU_MISALIGN_TRAP_EN undefined:
  - The misalign_err port is absent.
  - Misaligned addresses are force-aligned (word: addr[1:0] cleared; half: addr[0] cleared) and the access proceeds normally.

Test Plan:
- Reset asserted during WAIT (addr 0x100, store), ack arrives 2 cycles after release -> dmem_req=0 after reset, ack ignored, no memory write, mem_stall=0.
- LW addr 0x0000_0040, ack in first WAIT cycle, rdata 0xDEADBEEF -> dmem_addr=0x40, be=1111, mem_stall high 2 cycles, DMEM_data_out=0xDEADBEEF in DONE.
- LB addr 0x43, rdata 0x80FF_1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x42 -> 0x000080FF.
- SB addr 0x21, dataB 0x000000A5, ack after 3 wait cycles -> be=0010, wdata=0xA5A5A5A5, addr 0x20 stable throughout, stall 5 cycles total.
- SH addr 0x32, dataB 0x1234 -> be=1100, wdata=0x12341234; back-to-back second store starts only after the DONE cycle.
- LW addr 0x45 -> with MEMLSU_MISALIGN_TRAP_EN: no dmem_req, misalign_err 1-cycle pulse, no stall; without it: dmem_addr=0x44, normal access.
